// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter sequencer with a writable branch-target table.
// Define RELATIVE_BRANCH_EN for PC-relative table entries; otherwise entries are absolute targets.
module pc_sequencer #(
  parameter int D     = 10,
  parameter int AW    = 4,
  parameter int START = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          taken,
  input  logic [AW-1:0] lut_idx,
  input  logic          halt_req,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [D-1:0]  cfg_data,
  output logic [D-1:0]  pc,
  output logic          pc_valid,
  output logic          busy,
  output logic          done,
  output logic [15:0]   cyc_cnt
);

  localparam int N = 2 ** AW;
  localparam logic [D-1:0] START_PC = D'(START);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e       state_q;
  logic [D-1:0] pc_q;
  logic [15:0]  cnt_q;
  logic [D-1:0] tbl_q [N];

  logic [D-1:0] tbl_rd_d;
  logic [D-1:0] target_d;
  logic [D-1:0] pc_next_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign tbl_rd_d = tbl_q[lut_idx];

`ifdef RELATIVE_BRANCH_EN
  // Entry is a two's-complement offset; D-bit addition wraps modulo 2**D.
  logic signed [D-1:0] offset_d;
  assign offset_d = $signed(tbl_rd_d);
  assign target_d = pc_q + $unsigned(offset_d);
`else
  assign target_d = tbl_rd_d;
`endif

  always_comb begin
    pc_next_d = pc_q + {{(D-1){1'b0}}, 1'b1};
    if (branch_en && taken) pc_next_d = target_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      cnt_q   <= '0;
      for (int i = 0; i < N; i++) tbl_q[i] <= '0;
    end else begin
      // Table is only writable while the sequencer is not fetching.
      if (cfg_we && state_q != RUN) tbl_q[cfg_addr] <= cfg_data;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            pc_q    <= START_PC;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          if (!stall) begin
            cnt_q <= sat_inc(cnt_q);
            if (halt_req) state_q <= DONE;
            else          pc_q    <= pc_next_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pc       = pc_q;
  assign cyc_cnt  = cnt_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign pc_valid = (state_q == RUN) && !stall;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expected branch targets follow the RELATIVE_BRANCH_EN build.
module tb_pc_sequencer;
  localparam int D  = 10;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset, start, stall, branch_en, taken, halt_req, cfg_we;
  logic [AW-1:0] lut_idx, cfg_addr;
  logic [D-1:0]  cfg_data;
  logic [D-1:0]  pc;
  logic          pc_valid, busy, done;
  logic [15:0]   cyc_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  pc_sequencer #(.D(D), .AW(AW), .START(0)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_en(branch_en), .taken(taken), .lut_idx(lut_idx),
    .halt_req(halt_req), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .pc(pc), .pc_valid(pc_valid), .busy(busy),
    .done(done), .cyc_cnt(cyc_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] tgt(input logic [D-1:0] cur, input logic [D-1:0] entry);
`ifdef RELATIVE_BRANCH_EN
    return cur + entry;
`else
    return entry;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; stall = 0; branch_en = 0; taken = 0; lut_idx = '0;
    halt_req = 0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step(); step();
    reset = 0;
  endtask

  task automatic write_tbl(input logic [AW-1:0] a, input logic [D-1:0] v);
    cfg_we = 1; cfg_addr = a; cfg_data = v;
    step();
    cfg_we = 0;
  endtask

  task automatic branch(input logic [AW-1:0] idx);
    branch_en = 1; taken = 1; lut_idx = idx;
    step();
    branch_en = 0; taken = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; start = 1;
    step(); step();
    reset = 0; start = 0;
    n_chk++; if (pc !== 10'd0) begin n_fail++; $display("FAIL reset_pc got %0d want 0", pc); end
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got busy=%b done=%b vld=%b want 0,0,0", busy, done, pc_valid); end
    n_chk++; if (cyc_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cyc_cnt); end
  endtask

  task automatic test_run();
    write_tbl(4'd1, 10'd11);
    write_tbl(4'd2, 10'd44);
    start = 1; step(); start = 0;
    n_chk++; if (pc !== 10'd0 || busy !== 1'b1 || cyc_cnt !== 16'd0) begin
      n_fail++; $display("FAIL run_start got pc=%0d busy=%b cnt=%0d want 0,1,0", pc, busy, cyc_cnt); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_chk++; if (pc !== D'(i) || cyc_cnt !== 16'(i) || pc_valid !== 1'b1) begin
        n_fail++; $display("FAIL run_inc got pc=%0d cnt=%0d vld=%b want %0d,%0d,1", pc, cyc_cnt, pc_valid, i, i); end
    end
  endtask

  task automatic test_branch();
    logic [D-1:0] e;
    e = tgt(10'd3, 10'd44);
    branch(4'd2);
    n_chk++; if (pc !== e || cyc_cnt !== 16'd4) begin
      n_fail++; $display("FAIL branch_taken got pc=%0d cnt=%0d want %0d,4", pc, cyc_cnt, e); end
    branch_en = 1; taken = 0; lut_idx = 4'd2;
    step();
    branch_en = 0;
    n_chk++; if (pc !== e + 10'd1 || cyc_cnt !== 16'd5) begin
      n_fail++; $display("FAIL branch_not_taken got pc=%0d cnt=%0d want %0d,5", pc, cyc_cnt, e + 10'd1); end
  endtask

  task automatic test_table_wrap();
    logic [D-1:0] e;
    do_reset();
    write_tbl(4'd9, 10'h3FF);
    write_tbl(4'd10, 10'h3ED);
    write_tbl(4'd11, 10'd20);
    start = 1; step(); start = 0;
    repeat (4) step();
    n_chk++; if (pc !== 10'd4) begin n_fail++; $display("FAIL tbl_pre got pc=%0d want 4", pc); end
    e = tgt(10'd4, 10'h3FF);
    branch(4'd9);
    n_chk++; if (pc !== e) begin n_fail++; $display("FAIL tbl_neg got pc=%0h want %0h", pc, e); end
    e = tgt(e, 10'h3ED);
    branch(4'd10);
    n_chk++; if (pc !== e) begin n_fail++; $display("FAIL tbl_far got pc=%0h want %0h", pc, e); end
    e = tgt(e, 10'd20);
    branch(4'd11);
    n_chk++; if (pc !== e) begin n_fail++; $display("FAIL tbl_wrap got pc=%0h want %0h", pc, e); end
  endtask

  task automatic test_stall_halt();
    do_reset();
    start = 1; step(); start = 0;
    repeat (7) step();
    stall = 1; halt_req = 1;
    #1;
    n_chk++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL stall_vld got %b want 0", pc_valid); end
    step(); step();
    n_chk++; if (pc !== 10'd7 || cyc_cnt !== 16'd7 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL stall_hold got pc=%0d cnt=%0d busy=%b done=%b want 7,7,1,0", pc, cyc_cnt, busy, done); end
    stall = 0;
    #1;
    n_chk++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL unstall_vld got %b want 1", pc_valid); end
    step();
    halt_req = 0;
    n_chk++; if (pc !== 10'd7 || cyc_cnt !== 16'd8 || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL halt got pc=%0d cnt=%0d busy=%b done=%b want 7,8,0,1", pc, cyc_cnt, busy, done); end
    step();
    n_chk++; if (pc !== 10'd7 || cyc_cnt !== 16'd8 || done !== 1'b1 || pc_valid !== 1'b0) begin
      n_fail++; $display("FAIL done_hold got pc=%0d cnt=%0d done=%b vld=%b want 7,8,1,0", pc, cyc_cnt, done, pc_valid); end
  endtask

  task automatic test_cfg_in_run();
    write_tbl(4'd1, 10'd11);
    start = 1; step(); start = 0;
    n_chk++; if (pc !== 10'd0 || cyc_cnt !== 16'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart1 got pc=%0d cnt=%0d busy=%b want 0,0,1", pc, cyc_cnt, busy); end
    write_tbl(4'd1, 10'd99);
    halt_req = 1; step(); halt_req = 0;
    n_chk++; if (done !== 1'b1 || pc !== 10'd1 || cyc_cnt !== 16'd2) begin
      n_fail++; $display("FAIL halt2 got done=%b pc=%0d cnt=%0d want 1,1,2", done, pc, cyc_cnt); end
    start = 1; step(); start = 0;
    n_chk++; if (pc !== 10'd0 || cyc_cnt !== 16'd0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL restart2 got pc=%0d cnt=%0d busy=%b want 0,0,1", pc, cyc_cnt, busy); end
    branch(4'd1);
    n_chk++; if (pc !== tgt(10'd0, 10'd11)) begin
      n_fail++; $display("FAIL run_write_dropped got pc=%0d want %0d", pc, tgt(10'd0, 10'd11)); end
    start = 1; step(); start = 0;
    n_chk++; if (pc !== tgt(10'd0, 10'd11) + 10'd1 || cyc_cnt !== 16'd2) begin
      n_fail++; $display("FAIL start_in_run got pc=%0d cnt=%0d want %0d,2", pc, cyc_cnt, tgt(10'd0, 10'd11) + 10'd1); end
  endtask

  task automatic test_cfg_with_start();
    logic [D-1:0] e;
    do_reset();
    write_tbl(4'd4, 10'd5);
    write_tbl(4'd4, 10'd6);
    cfg_we = 1; cfg_addr = 4'd3; cfg_data = 10'd200; start = 1;
    step();
    cfg_we = 0; start = 0;
    e = tgt(10'd0, 10'd200);
    branch(4'd3);
    n_chk++; if (pc !== e) begin n_fail++; $display("FAIL cfg_start got pc=%0d want %0d", pc, e); end
    e = tgt(e, 10'd6);
    branch(4'd4);
    n_chk++; if (pc !== e) begin n_fail++; $display("FAIL last_write got pc=%0d want %0d", pc, e); end
  endtask

  task automatic test_wrap_reset();
    do_reset();
    write_tbl(4'd2, 10'd44);
    start = 1; step(); start = 0;
    repeat (1023) step();
    n_chk++; if (pc !== 10'h3FF || cyc_cnt !== 16'd1023) begin
      n_fail++; $display("FAIL pre_wrap got pc=%0h cnt=%0d want 3ff,1023", pc, cyc_cnt); end
    step();
    n_chk++; if (pc !== 10'd0 || cyc_cnt !== 16'd1024) begin
      n_fail++; $display("FAIL wrap got pc=%0h cnt=%0d want 0,1024", pc, cyc_cnt); end
    step();
    reset = 1; step(); reset = 0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || pc !== 10'd0 || cyc_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_reset got busy=%b done=%b pc=%0d cnt=%0d want 0,0,0,0", busy, done, pc, cyc_cnt); end
    start = 1; step(); start = 0;
    branch(4'd2);
    n_chk++; if (pc !== tgt(10'd0, 10'd0)) begin
      n_fail++; $display("FAIL tbl_cleared got pc=%0d want %0d", pc, tgt(10'd0, 10'd0)); end
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    #1;
    test_reset();
    test_run();
    test_branch();
    test_table_wrap();
    test_stall_halt();
    test_cfg_in_run();
    test_cfg_with_start();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
